// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with valid/ready flow control on both sides.
// The WIDTH-bit carry chain is cut into STAGES slices of WIDTH/STAGES bits;
// slice k is added in pipeline stage k using the carry registered by stage k-1.
// Operands travel down the pipe with their beat so later slices can consume
// them, and finished low slices ride along so the result is aligned at the end.
// Optional feature: define PIPE_ADDER_SAT_EN to clamp the result to the signed
// max/min on overflow (cout/overflow still describe the raw sum).
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int unsigned C   = WIDTH / STAGES;
    localparam int unsigned Msb = WIDTH - 1;

    // Index k carries the beat entering stage k; index STAGES is the output stage.
    logic             st_v [STAGES+1];
    logic [WIDTH-1:0] st_a [STAGES+1];
    logic [WIDTH-1:0] st_b [STAGES+1];
    logic [WIDTH-1:0] st_s [STAGES+1];
    logic             st_c [STAGES+1];

    logic stall;

    // Subtraction is folded into the operands before the first slice.
    assign st_v[0] = in_valid_i;
    assign st_a[0] = a_i;
    assign st_b[0] = sub_i ? ~b_i : b_i;
    assign st_c[0] = cin_i ^ sub_i;
    assign st_s[0] = '0;

    // The whole pipe freezes while a result waits on the consumer.
    assign stall      = st_v[STAGES] && !out_ready_i;
    assign in_ready_o = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic [C:0]       slc;
        logic [WIDTH-1:0] s_d;

        assign slc = {1'b0, st_a[k][k*C +: C]} + {1'b0, st_b[k][k*C +: C]}
                   + {{C{1'b0}}, st_c[k]};

        // Merge this stage's slice into the partially built result.
        always_comb begin
            s_d             = st_s[k];
            s_d[k*C +: C]   = slc[C-1:0];
        end

        // Stage register: holds on stall, loads data only for valid beats.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (!stall) begin
                v_q <= st_v[k];
                if (st_v[k]) begin
                    a_q <= st_a[k];
                    b_q <= st_b[k];
                    s_q <= s_d;
                    c_q <= slc[C];
                end
            end
        end

        assign st_v[k+1] = v_q;
        assign st_a[k+1] = a_q;
        assign st_b[k+1] = b_q;
        assign st_s[k+1] = s_q;
        assign st_c[k+1] = c_q;
    end

    logic [WIDTH-1:0] raw_sum;
    logic             a_msb;
    logic             unused_ab;

    assign raw_sum     = st_s[STAGES];
    assign a_msb       = st_a[STAGES][Msb];
    assign out_valid_o = st_v[STAGES];
    assign cout_o      = st_c[STAGES];
    assign overflow_o  = (a_msb == st_b[STAGES][Msb]) && (raw_sum[Msb] != a_msb);
    // Only the sign bits of the operands matter once the last slice is done.
    assign unused_ab   = ^{st_a[STAGES][Msb-1:0], st_b[STAGES][Msb-1:0]};

`ifdef PIPE_ADDER_SAT_EN
    // Clamp toward the sign of A; both operands share that sign on overflow.
    assign sum_o = !overflow_o ? raw_sum
                 : a_msb       ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign sum_o = raw_sum;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three instances (32/4, 32/1, 8/8).
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  iv;
    logic        out_ready;
    logic [31:0] a_r, b_r;
    logic        cin_r, sub_r;

    logic        ir0, ov0, co0, of0;
    logic [31:0] so0;
    logic        ir1, ov1, co1, of1;
    logic [31:0] so1;
    logic        ir2, ov2, co2, of2;
    logic [7:0]  so2;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        bit          lat;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic        hv [3];
    logic [31:0] hs [3];
    logic        hc [3];
    logic        ho [3];

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir0),
        .a_i(a_r), .b_i(b_r), .cin_i(cin_r), .sub_i(sub_r),
        .out_valid_o(ov0), .out_ready_i(out_ready), .sum_o(so0), .cout_o(co0),
        .overflow_o(of0)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(1)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir1),
        .a_i(a_r), .b_i(b_r), .cin_i(cin_r), .sub_i(sub_r),
        .out_valid_o(ov1), .out_ready_i(out_ready), .sum_o(so1), .cout_o(co1),
        .overflow_o(of1)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir2),
        .a_i(a_r[7:0]), .b_i(b_r[7:0]), .cin_i(cin_r), .sub_i(sub_r),
        .out_valid_o(ov2), .out_ready_i(out_ready), .sum_o(so2), .cout_o(co2),
        .overflow_o(of2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pick(input logic [31:0] wrapv, input logic [31:0] satv);
`ifdef PIPE_ADDER_SAT_EN
        return satv;
`else
        return wrapv;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic qpush(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic logic rdy(input int id);
        case (id)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    // Monitor for one instance: hold stability, stall backpressure, scoreboard pop.
    task automatic mon(input int id, input logic v, input logic r, input logic [31:0] s,
                       input logic c, input logic o);
        exp_t e;
        if (hv[id]) begin
            chk($sformatf("d%0d_hold_valid", id), {31'b0, v}, 32'd1);
            chk($sformatf("d%0d_hold_sum", id), s, hs[id]);
            chk($sformatf("d%0d_hold_cout", id), {31'b0, c}, {31'b0, hc[id]});
            chk($sformatf("d%0d_hold_ovf", id), {31'b0, o}, {31'b0, ho[id]});
        end
        hv[id] = 1'b0;
        if (v && !out_ready) begin
            chk($sformatf("d%0d_stall_in_ready", id), {31'b0, r}, 32'd0);
            hv[id] = 1'b1;
            hs[id] = s;
            hc[id] = c;
            ho[id] = o;
        end
        if (v && out_ready) begin
            if (qsize(id) == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL d%0d_unexpected_out actual=%h required=no_output", id, s);
            end else begin
                e = qpop(id);
                chk($sformatf("d%0d_sum", id), s, e.s);
                chk($sformatf("d%0d_cout", id), {31'b0, c}, {31'b0, e.c});
                chk($sformatf("d%0d_ovf", id), {31'b0, o}, {31'b0, e.o});
                if (e.lat) chk($sformatf("d%0d_latency", id), cyc, e.due);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov0, ir0, so0, co0, of0);
        mon(1, ov1, ir1, so1, co1, of1);
        mon(2, ov2, ir2, {24'h0, so2}, co2, of2);
    end

    // Present one beat, wait for acceptance, push its expected result.
    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic [31:0] es,
                        input logic ec, input logic eo, input bit lat);
        exp_t e;
        bit   done;
        int   st;
        st    = (id == 0) ? 4 : (id == 1) ? 1 : 8;
        a_r   = a;
        b_r   = b;
        cin_r = c;
        sub_r = s;
        iv[id] = 1'b1;
        done  = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (rdy(id)) begin
                e.s   = es;
                e.c   = ec;
                e.o   = eo;
                e.lat = lat;
                e.due = cyc + st;
                qpush(id, e);
                done  = 1'b1;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL d%0d_accept_timeout actual=in_ready_low required=accept", id);
        end
        @(posedge clk);
        #1;
        iv[id] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (q0.size() + q1.size() + q2.size()) != 0; t++)
            @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_pending", q0.size() + q1.size() + q2.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) hv[i] = 1'b0;
        iv        = 3'b000;
        out_ready = 1'b1;
        a_r       = '0;
        b_r       = '0;
        cin_r     = 1'b0;
        sub_r     = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, ov0}, 32'd0);
        chk("rst_sum", so0, 32'd0);
        chk("rst_cout", {31'b0, co0}, 32'd0);
        chk("rst_ovf", {31'b0, of0}, 32'd0);
        #21;
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", {31'b0, ir0}, 32'd1);
        @(posedge clk);
        #1;

        // Basic add, carry chain end to end, signed overflow, subtraction.
        send(0, 32'h00000003, 32'h00000052, 1'b1, 1'b0, 32'h00000056, 1'b0, 1'b0, 1'b1);
        send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        send(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
             pick(32'h80000000, 32'h7FFFFFFF), 1'b0, 1'b1, 1'b1);
        send(0, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
        send(0, 32'h80000000, 32'h00000001, 1'b0, 1'b1,
             pick(32'h7FFFFFFF, 32'h80000000), 1'b1, 1'b1, 1'b1);
        drain();

        // Streaming with a 3-cycle downstream stall mid-stream.
        fork
            begin
                send(0, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
                send(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
                send(0, 32'h63AE6AAF, 32'h09AE7CF2, 1'b1, 1'b0, 32'h6D5CE7A2, 1'b0, 1'b0, 1'b0);
                send(0, 32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0);
                send(0, 32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0);
                send(0, 32'h80000000, 32'h80000000, 1'b0, 1'b0,
                     pick(32'h00000000, 32'h80000000), 1'b1, 1'b1, 1'b0);
                send(0, 32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000C, 1'b1, 1'b0, 1'b0);
                send(0, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with beats in flight: everything in the pipe is dropped.
        for (int i = 0; i < 6; i++)
            send(0, i, i, 1'b0, 1'b0, 2 * i, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("midrst_out_valid", {31'b0, ov0}, 32'd0);
        chk("midrst_sum", so0, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(0, 32'h00000100, 32'h00000023, 1'b0, 1'b0, 32'h00000123, 1'b0, 1'b0, 1'b1);
        drain();

        // Single-stage 32-bit and fully sliced 8-bit variants.
        send(1, 32'h00000003, 32'h00000052, 1'b1, 1'b0, 32'h00000056, 1'b0, 1'b0, 1'b1);
        send(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        send(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
             pick(32'h80000000, 32'h7FFFFFFF), 1'b0, 1'b1, 1'b1);
        send(1, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
        send(2, 32'h00000003, 32'h00000052, 1'b1, 1'b0, 32'h00000056, 1'b0, 1'b0, 1'b1);
        send(2, 32'h000000FF, 32'h000000FF, 1'b1, 1'b0, 32'h000000FF, 1'b1, 1'b0, 1'b1);
        send(2, 32'h0000007F, 32'h00000001, 1'b0, 1'b0,
             pick(32'h00000080, 32'h0000007F), 1'b0, 1'b1, 1'b1);
        send(2, 32'h00000080, 32'h00000001, 1'b0, 1'b1,
             pick(32'h0000007F, 32'h00000080), 1'b1, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
